// File: rtl/owm_byte_seq.sv
// Byte sequencer for the 1-wire bit engine: expands RESET/WRITE/READ/TRIPLET into owm slots.
// First start one cycle after accept (if owm ready); one command in flight, cmd_ready low until RESP ends; no rsp backpressure.
module owm_byte_seq #(
  parameter int OW_BUS_NUM = 1,
  parameter int OW_ADDR_W  = (OW_BUS_NUM == 1) ? 1 : $clog2(OW_BUS_NUM)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [1:0]           cmd_op_i,
  input  logic [OW_ADDR_W-1:0] cmd_addr_i,
  input  logic [7:0]           cmd_data_i,
  output logic                 rsp_valid_o,
  output logic [7:0]           rsp_data_o,
  output logic                 rsp_presence_o,
  output logic                 rsp_err_o,
  output logic                 busy_o,
  output logic                 owm_start_o,
  output logic [2:0]           owm_cmd_o,
  output logic [OW_ADDR_W-1:0] owm_addr_o,
  output logic                 owm_wrdat_o,
  input  logic                 owm_rddat_i,
  input  logic                 owm_presence_i,
  input  logic                 owm_ready_i
);

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_TRIP  = 2'b11;

  localparam logic [2:0] OWM_RST = 3'b001;
  localparam logic [2:0] OWM_WR  = 3'b010;
  localparam logic [2:0] OWM_RD  = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_NEXT, S_RESP
  } state_t;

  state_t               r_state;
  logic [1:0]           r_op;
  logic [7:0]           r_data;
  logic [2:0]           r_bit;
  logic [1:0]           r_phase;
  logic [7:0]           r_shift;
  logic                 r_smp_bit;
  logic                 r_smp_pres;
  logic                 r_id;
  logic                 r_cmp;
  logic                 r_dir;
  logic [2:0]           r_owm_cmd;
  logic [OW_ADDR_W-1:0] r_owm_addr;
  logic                 r_owm_wrdat;
  logic                 r_rsp_valid;
  logic [7:0]           r_rsp_data;
  logic                 r_rsp_presence;
  logic                 r_rsp_err;

  logic                 w_bit_last;
  logic [2:0]           w_bit_inc;
  logic                 w_tri_dir;
  logic [7:0]           w_shift_nxt;

  assign w_bit_last = (r_bit == 3'd7);
  assign w_bit_inc  = r_bit + 3'd1;
  // Differing id/cmp: only one branch populated. Both 0: fork, take preferred. Both 1: nobody, force 1.
  assign w_tri_dir  = (r_id != r_smp_bit) ? r_id : (r_id | r_data[0]);

  always_comb begin
    w_shift_nxt        = r_shift;
    w_shift_nxt[r_bit] = r_smp_bit;
  end

  assign cmd_ready_o    = (r_state == S_IDLE);
  assign busy_o         = ~cmd_ready_o;
  assign owm_start_o    = (r_state == S_ISSUE) && owm_ready_i;
  assign owm_cmd_o      = r_owm_cmd;
  assign owm_addr_o     = r_owm_addr;
  assign owm_wrdat_o    = r_owm_wrdat;
  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_data_o     = r_rsp_data;
  assign rsp_presence_o = r_rsp_presence;
  assign rsp_err_o      = r_rsp_err;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state        <= S_IDLE;
      r_op           <= OP_RESET;
      r_data         <= 8'h00;
      r_bit          <= 3'd0;
      r_phase        <= 2'd0;
      r_shift        <= 8'h00;
      r_smp_bit      <= 1'b0;
      r_smp_pres     <= 1'b0;
      r_id           <= 1'b0;
      r_cmp          <= 1'b0;
      r_dir          <= 1'b0;
      r_owm_cmd      <= 3'b000;
      r_owm_addr     <= '0;
      r_owm_wrdat    <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_data     <= 8'h00;
      r_rsp_presence <= 1'b0;
      r_rsp_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            r_op        <= cmd_op_i;
            r_data      <= cmd_data_i;
            r_bit       <= 3'd0;
            r_phase     <= 2'd0;
            r_shift     <= 8'h00;
            r_owm_addr  <= cmd_addr_i;
            r_owm_wrdat <= (cmd_op_i == OP_WRITE) && cmd_data_i[0];
            case (cmd_op_i)
              OP_RESET: r_owm_cmd <= OWM_RST;
              OP_WRITE: r_owm_cmd <= OWM_WR;
              default:  r_owm_cmd <= OWM_RD;
            endcase
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (owm_ready_i) r_state <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (!owm_ready_i) r_state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (owm_ready_i) begin
            r_smp_bit  <= owm_rddat_i;
            r_smp_pres <= owm_presence_i;
            r_state    <= S_NEXT;
          end
        end
        S_NEXT: begin
          case (r_op)
            OP_RESET: begin
              r_rsp_presence <= r_smp_pres;
              r_rsp_data     <= 8'h00;
              r_rsp_valid    <= 1'b1;
              r_state        <= S_RESP;
            end
            OP_WRITE: begin
              if (w_bit_last) begin
                r_rsp_data  <= r_data;
                r_rsp_valid <= 1'b1;
                r_state     <= S_RESP;
              end else begin
                r_bit       <= w_bit_inc;
                r_owm_wrdat <= r_data[w_bit_inc];
                r_state     <= S_ISSUE;
              end
            end
            OP_READ: begin
              r_shift <= w_shift_nxt;
              if (w_bit_last) begin
                r_rsp_data  <= w_shift_nxt;
                r_rsp_valid <= 1'b1;
                r_state     <= S_RESP;
              end else begin
                r_bit   <= w_bit_inc;
                r_state <= S_ISSUE;
              end
            end
            default: begin
              // Triplet: phase 0 reads id, phase 1 reads cmp, phase 2 has written dir
              case (r_phase)
                2'd0: begin
                  r_id    <= r_smp_bit;
                  r_phase <= 2'd1;
                  r_state <= S_ISSUE;
                end
                2'd1: begin
                  r_cmp       <= r_smp_bit;
                  r_dir       <= w_tri_dir;
                  r_owm_cmd   <= OWM_WR;
                  r_owm_wrdat <= w_tri_dir;
                  r_phase     <= 2'd2;
                  r_state     <= S_ISSUE;
                end
                default: begin
                  r_rsp_data  <= {5'b00000, r_dir, r_cmp, r_id};
                  r_rsp_err   <= r_id & r_cmp;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
                end
              endcase
            end
          endcase
        end
        S_RESP: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
